// File: rtl/inverse_cipher_if.sv
// Block-level handshake and key-store bus between the decryption front-end,
// the key schedule store, the plaintext consumer and the inverse-cipher controller.
interface inverse_cipher_if #(
    parameter int unsigned KEY_INDEX_W = 4
);
    logic                   keyReady;
    logic                   inValid;
    logic                   inReady;
    logic [127:0]           cipherText;
    logic [KEY_INDEX_W-1:0] keyIndex;
    logic [127:0]           roundKey;
    logic                   outValid;
    logic                   outReady;
    logic [127:0]           plainText;
    logic                   busy;

    modport master (
        output keyReady, inValid, cipherText, roundKey, outReady,
        input  inReady, keyIndex, outValid, plainText, busy
    );

    modport slave (
        input  keyReady, inValid, cipherText, roundKey, outReady,
        output inReady, keyIndex, outValid, plainText, busy
    );
endinterface

// File: rtl/inverse_cipher_controller.sv
// Iterative AES inverse-cipher sequencer: one 128-bit state register folded
// through a single combinational inverse round per clock.
module inverse_cipher_controller #(
    parameter int unsigned NUM_ROUNDS  = 10,
    parameter int unsigned KEY_INDEX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    inverse_cipher_if.slave io_bus
);
    localparam int unsigned BLOCK_W = 128;
    localparam logic [KEY_INDEX_W-1:0] LAST_KEY  = KEY_INDEX_W'(NUM_ROUNDS);
    localparam logic [KEY_INDEX_W-1:0] FIRST_RND = KEY_INDEX_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [BLOCK_W-1:0]     r_data, w_data_nxt, w_round_out;
    logic [KEY_INDEX_W-1:0] r_round_cnt, w_round_cnt_nxt;
    logic [KEY_INDEX_W-1:0] r_key_index, w_key_index_nxt;
    logic                   r_out_valid, r_busy;
    logic                   w_in_ready, w_mix_en;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b, x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
        b    = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        x2   = gf_mul(b, b);
        x3   = gf_mul(x2, b);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, b);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, b);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, b);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, b);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, b);
        return gf_mul(x127, x127);
    endfunction

    // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
    function automatic logic [BLOCK_W-1:0] inv_round(input logic [BLOCK_W-1:0] st,
                                                     input logic [BLOCK_W-1:0] key,
                                                     input logic               mix_en);
        logic [7:0]         b [16];
        logic [BLOCK_W-1:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = inv_sbox(st[127-8*(4*((c-r)&3)+r) -: 8]) ^ key[127-8*(4*c+r) -: 8];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (mix_en)
                    res[127-8*(4*c+r) -: 8] = gf_mul(b[4*c+r], 8'h0e)
                                            ^ gf_mul(b[4*c+((r+1)&3)], 8'h0b)
                                            ^ gf_mul(b[4*c+((r+2)&3)], 8'h0d)
                                            ^ gf_mul(b[4*c+((r+3)&3)], 8'h09);
                else
                    res[127-8*(4*c+r) -: 8] = b[4*c+r];
        return res;
    endfunction

    assign w_in_ready  = rst_n && (r_state == S_IDLE) && io_bus.keyReady;
    assign w_mix_en    = (r_round_cnt != '0);
    assign w_round_out = inv_round(r_data, io_bus.roundKey, w_mix_en);

    // Next-state and datapath selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_round_cnt_nxt = r_round_cnt;
        w_key_index_nxt = r_key_index;
        case (r_state)
            S_IDLE: begin
                if (io_bus.inValid && w_in_ready) begin
                    w_data_nxt  = io_bus.cipherText;
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                w_data_nxt      = r_data ^ io_bus.roundKey;
                w_round_cnt_nxt = FIRST_RND;
                w_key_index_nxt = FIRST_RND;
                w_state_nxt     = S_ROUND;
            end
            S_ROUND: begin
                w_data_nxt = w_round_out;
                if (r_round_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_round_cnt_nxt = r_round_cnt - KEY_INDEX_W'(1);
                    w_key_index_nxt = r_round_cnt - KEY_INDEX_W'(1);
                end
            end
            S_DONE: begin
                if (io_bus.outReady) begin
                    w_state_nxt     = S_IDLE;
                    w_key_index_nxt = LAST_KEY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_round_cnt <= '0;
            r_key_index <= LAST_KEY;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_round_cnt <= w_round_cnt_nxt;
            r_key_index <= w_key_index_nxt;
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign io_bus.inReady   = w_in_ready;
    assign io_bus.keyIndex  = r_key_index;
    assign io_bus.outValid  = r_out_valid;
    assign io_bus.plainText = r_data;
    assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_inverse_cipher_controller.sv
// Bench for inverse_cipher_controller: FIPS-197 vectors plus random blocks
// checked against a table-driven AES-128 decryption model.
module tb_inverse_cipher_controller;
    localparam int NR = 10;
    localparam int KW = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];
    int           trace [$];

    inverse_cipher_if #(.KEY_INDEX_W(KW)) bus ();

    inverse_cipher_controller #(.NUM_ROUNDS(NR), .KEY_INDEX_W(KW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Key schedule store: combinational read by index.
    assign bus.roundKey = rk[bus.keyIndex];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p ^= aa;
            aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from brute-force field inverse plus affine map; inverse table by lookup.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            if (r <= NR) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = '0;
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [7:0]   s  [4][4];
        logic [7:0]   t  [4][4];
        logic [7:0]   mc [4];
        logic [127:0] key, res;
        mc[0] = 8'h0e; mc[1] = 8'h0b; mc[2] = 8'h0d; mc[3] = 8'h09;
        key = rk[NR];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127-8*(4*c+r) -: 8] ^ key[127-8*(4*c+r) -: 8];
        for (int rnd = NR - 1; rnd >= 0; rnd--) begin
            key = rk[rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c + r) % 4] = s[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = isbox[t[r][c]] ^ key[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd == 0) s[r][c] = t[r][c];
                    else begin
                        s[r][c] = 8'h00;
                        for (int k = 0; k < 4; k++) s[r][c] ^= gmul(mc[(k - r + 4) % 4], t[k][c]);
                    end
                end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block with outReady high; records keyIndex per cycle from the handshake cycle.
    task automatic send_block(input logic [127:0] ct, output int lat, output logic [127:0] pt,
                              output bit got);
        bit acc;
        acc = 1'b0; got = 1'b0; lat = -1; pt = '0;
        trace.delete();
        bus.cipherText = ct; bus.inValid = 1'b1; bus.outReady = 1'b1;
        for (int w = 0; w < 50; w++) begin
            #1;
            if (bus.inReady === 1'b1) begin acc = 1'b1; break; end
            step();
        end
        if (acc) begin
            trace.push_back(int'(bus.keyIndex));
            for (int k = 1; k <= 60; k++) begin
                step();
                bus.inValid = 1'b0;
                #1;
                trace.push_back(int'(bus.keyIndex));
                if (bus.outValid === 1'b1) begin lat = k; pt = bus.plainText; got = 1'b1; break; end
            end
        end
        bus.inValid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus.keyReady = 1'b1; bus.inValid = 1'b1; bus.outReady = 1'b1; bus.cipherText = rand128();
        repeat (3) step();
        #1;
        n_checks++; if (bus.inReady !== 1'b0) begin n_errors++; $display("FAIL reset_inReady: got %b expected 0", bus.inReady); end
        n_checks++; if (bus.outValid !== 1'b0) begin n_errors++; $display("FAIL reset_outValid: got %b expected 0", bus.outValid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.keyIndex !== 4'(NR)) begin n_errors++; $display("FAIL reset_keyIndex: got %0d expected %0d", bus.keyIndex, NR); end
        n_checks++; if (bus.plainText !== 128'h0) begin n_errors++; $display("FAIL reset_plainText: got %h expected 0", bus.plainText); end
        bus.inValid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.inReady !== 1'b1) begin n_errors++; $display("FAIL idle_inReady: got %b expected 1", bus.inReady); end
        step();
    endtask

    task automatic test_fips_c1();
        int lat, exp_idx, obs_idx;
        logic [127:0] pt;
        bit got;
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat, pt, got);
        n_checks++; if (got !== 1'b1) begin n_errors++; $display("FAIL c1_timeout: got outValid=%b expected 1", got); end
        n_checks++; if (lat != NR + 2) begin n_errors++; $display("FAIL c1_latency: got %0d expected %0d", lat, NR + 2); end
        n_checks++; if (pt !== 128'h00112233445566778899aabbccddeeff) begin n_errors++; $display("FAIL c1_plainText: got %h expected 00112233445566778899aabbccddeeff", pt); end
        for (int i = 0; i < NR + 2; i++) begin
            exp_idx = (i < 2) ? NR : NR + 1 - i;
            obs_idx = (i < trace.size()) ? trace[i] : -1;
            n_checks++; if (obs_idx != exp_idx) begin n_errors++; $display("FAIL c1_keyIndex[%0d]: got %0d expected %0d", i, obs_idx, exp_idx); end
        end
        #1;
        n_checks++; if (bus.outValid !== 1'b0) begin n_errors++; $display("FAIL c1_pulse: got outValid=%b expected 0", bus.outValid); end
        n_checks++; if (bus.inReady !== 1'b1) begin n_errors++; $display("FAIL c1_rearm: got inReady=%b expected 1", bus.inReady); end
    endtask

    task automatic test_fips_b();
        int lat;
        logic [127:0] pt;
        bit got;
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        send_block(128'h3925841d02dc09fbdc118597196a0b32, lat, pt, got);
        n_checks++; if (pt !== 128'h3243f6a8885a308d313198a2e0370734) begin n_errors++; $display("FAIL b_plainText: got %h expected 3243f6a8885a308d313198a2e0370734", pt); end
        n_checks++; if (lat != NR + 2) begin n_errors++; $display("FAIL b_latency: got %0d expected %0d", lat, NR + 2); end
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] pt, ct, exp_pt;
        bit got;
        for (int n = 0; n < 6; n++) begin
            expand_key(rand128());
            ct     = rand128();
            exp_pt = ref_decrypt(ct);
            send_block(ct, lat, pt, got);
            n_checks++; if (pt !== exp_pt) begin n_errors++; $display("FAIL rand%0d_plainText: got %h expected %h", n, pt, exp_pt); end
            n_checks++; if (lat != NR + 2) begin n_errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, NR + 2); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] ct, exp_pt;
        bit found;
        expand_key(rand128());
        ct = rand128();
        exp_pt = ref_decrypt(ct);
        bus.outReady = 1'b0; bus.cipherText = ct; bus.inValid = 1'b1;
        step();
        bus.inValid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (bus.outValid === 1'b1) begin found = 1'b1; break; end
            step();
        end
        n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL bp_timeout: got outValid=%b expected 1", found); end
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (bus.plainText !== exp_pt) begin n_errors++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, bus.plainText, exp_pt); end
            n_checks++; if (bus.inReady !== 1'b0) begin n_errors++; $display("FAIL bp_inReady[%0d]: got %b expected 0", i, bus.inReady); end
            step();
            #1;
        end
        n_checks++; if (bus.keyIndex !== 4'd0) begin n_errors++; $display("FAIL bp_keyIndex: got %0d expected 0", bus.keyIndex); end
        n_checks++; if (bus.outValid !== 1'b1) begin n_errors++; $display("FAIL bp_outValid: got %b expected 1", bus.outValid); end
        bus.outReady = 1'b1;
        step();
        #1;
        n_checks++; if (bus.outValid !== 1'b0) begin n_errors++; $display("FAIL bp_release_outValid: got %b expected 0", bus.outValid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL bp_release_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.inReady !== 1'b1) begin n_errors++; $display("FAIL bp_release_inReady: got %b expected 1", bus.inReady); end
        step();
    endtask

    task automatic test_guard();
        bus.keyReady = 1'b0; bus.inValid = 1'b1; bus.outReady = 1'b1; bus.cipherText = rand128();
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (bus.inReady !== 1'b0) begin n_errors++; $display("FAIL guard_inReady[%0d]: got %b expected 0", i, bus.inReady); end
            n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL guard_busy[%0d]: got %b expected 0", i, bus.busy); end
            step();
        end
        bus.inValid = 1'b0; bus.keyReady = 1'b1;
        #1;
        n_checks++; if (bus.inReady !== 1'b1) begin n_errors++; $display("FAIL guard_restore: got %b expected 1", bus.inReady); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct_a, ct_b, exp_a, exp_b;
        int           hs [$];
        logic [127:0] outs [$];
        expand_key(rand128());
        ct_a = rand128(); ct_b = rand128();
        exp_a = ref_decrypt(ct_a); exp_b = ref_decrypt(ct_b);
        bus.inValid = 1'b1; bus.cipherText = ct_a; bus.outReady = 1'b1;
        for (int cyc = 0; cyc < 80 && outs.size() < 2; cyc++) begin
            #1;
            if (bus.inValid === 1'b1 && bus.inReady === 1'b1) hs.push_back(cyc);
            if (bus.outValid === 1'b1) outs.push_back(bus.plainText);
            step();
            if (hs.size() == 1) bus.cipherText = ct_b;
            if (hs.size() >= 2) bus.inValid = 1'b0;
        end
        bus.inValid = 1'b0;
        n_checks++; if (hs.size() != 2) begin n_errors++; $display("FAIL b2b_handshakes: got %0d expected 2", hs.size()); end
        n_checks++; if (hs.size() != 2 || hs[1] - hs[0] != NR + 3) begin n_errors++; $display("FAIL b2b_spacing: got %0d handshakes, spacing expected %0d", hs.size(), NR + 3); end
        n_checks++; if (outs.size() != 2) begin n_errors++; $display("FAIL b2b_outputs: got %0d expected 2", outs.size()); end
        n_checks++; if (outs.size() < 1 || outs[0] !== exp_a) begin n_errors++; $display("FAIL b2b_first: got %0d outputs, expected %h", outs.size(), exp_a); end
        n_checks++; if (outs.size() < 2 || outs[1] !== exp_b) begin n_errors++; $display("FAIL b2b_second: got %0d outputs, expected %h", outs.size(), exp_b); end
    endtask

    task automatic test_reset_mid();
        int lat, rises;
        logic [127:0] pt;
        bit got;
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        bus.cipherText = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; bus.inValid = 1'b1; bus.outReady = 1'b1;
        step();
        bus.inValid = 1'b0;
        repeat (5) step();
        n_checks++; if (bus.keyIndex !== 4'(NR - 5)) begin n_errors++; $display("FAIL mid_keyIndex: got %0d expected %0d", bus.keyIndex, NR - 5); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.outValid !== 1'b0) begin n_errors++; $display("FAIL mid_outValid: got %b expected 0", bus.outValid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.plainText !== 128'h0) begin n_errors++; $display("FAIL mid_state: got %h expected 0", bus.plainText); end
        n_checks++; if (bus.keyIndex !== 4'(NR)) begin n_errors++; $display("FAIL mid_keyIndex_rst: got %0d expected %0d", bus.keyIndex, NR); end
        n_checks++; if (bus.inReady !== 1'b0) begin n_errors++; $display("FAIL mid_inReady: got %b expected 0", bus.inReady); end
        step();
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (bus.outValid !== 1'b0) rises++;
            step();
        end
        n_checks++; if (rises != 0) begin n_errors++; $display("FAIL mid_no_output: got %0d outValid cycles expected 0", rises); end
        send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat, pt, got);
        n_checks++; if (pt !== 128'h00112233445566778899aabbccddeeff) begin n_errors++; $display("FAIL mid_recover: got %h expected 00112233445566778899aabbccddeeff", pt); end
        n_checks++; if (lat != NR + 2) begin n_errors++; $display("FAIL mid_recover_latency: got %0d expected %0d", lat, NR + 2); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.keyReady = 1'b0; bus.inValid = 1'b0; bus.outReady = 1'b0; bus.cipherText = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_tables();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_random();
        test_backpressure();
        test_guard();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
